// File: rtl/sb_pkg.sv
// Shared sideband definitions: packet geometry and the TX serializer state encoding.
package sb_pkg;

    localparam int SB_DATA_W = 64;
    localparam int SB_GAP_UI = 32;

    typedef enum logic [1:0] {
        SER_IDLE,
        SER_LOADED,
        SER_SHIFT,
        SER_GAP
    } sb_ser_state_t;

endpackage

// File: rtl/sb_tx_ui_counter.sv
// Loadable UI up-counter with a registered-count terminal-count flag.
module sb_tx_ui_counter #(
    parameter int CNT_W = 7,
    parameter int TC    = 63
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_clear,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_load_val,
    input  logic             i_inc,
    output logic             o_tc
);

    localparam logic [CNT_W-1:0] TC_VAL = CNT_W'(TC);

    logic [CNT_W-1:0] count;

    // Clear wins over load so the FSM can retire a count on the same edge it would reload.
    always_ff @(posedge i_clk) begin
        if (i_rst || i_clear) begin
            count <= '0;
        end else if (i_load) begin
            count <= i_load_val;
        end else if (i_inc) begin
            count <= count + 1'b1;
        end
    end

    assign o_tc = (count == TC_VAL);

endmodule

// File: rtl/sb_tx_serializer.sv
// Sideband TX serializer: captures a FIFO word, shifts it out LSB-first under the
// FSM's shift enable, then holds the lane low for the inter-packet gap.
module sb_tx_serializer
    import sb_pkg::*;
#(
    parameter  int DATA_W = SB_DATA_W,
    parameter  int GAP_UI = SB_GAP_UI,
    localparam int CNT_W  = $clog2(DATA_W + 1)
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_load,
    input  logic [DATA_W-1:0] i_data,
    input  logic              i_clk_en,
    output logic              o_load_ack,
    output logic              o_zero_word,
    output logic              o_txdat,
    output logic              o_txclk_en,
    output logic              o_ser_done,
    output logic              o_packet_finished,
    output logic              o_overrun
);

    sb_ser_state_t     state, state_next;
    logic [DATA_W-1:0] sr, sr_next;
    logic              pending, pending_next;

    logic txdat_next;
    logic txclk_en_next;
    logic ser_done_next;
    logic pkt_fin_next;
    logic load_ack_next;
    logic zero_word_next;
    logic overrun_next;

    logic bit_clear, bit_load, bit_inc, bit_tc;
    logic gap_clear, gap_inc, gap_tc;

    // Bit counter is preloaded to 1 because the LOADED->SHIFT edge already drives bit 0.
    sb_tx_ui_counter #(
        .CNT_W (CNT_W),
        .TC    (DATA_W - 1)
    ) u_bit_cnt (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_clear    (bit_clear),
        .i_load     (bit_load),
        .i_load_val (CNT_W'(1)),
        .i_inc      (bit_inc),
        .o_tc       (bit_tc)
    );

    sb_tx_ui_counter #(
        .CNT_W (CNT_W),
        .TC    (GAP_UI - 1)
    ) u_gap_cnt (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_clear    (gap_clear),
        .i_load     (1'b0),
        .i_load_val ('0),
        .i_inc      (gap_inc),
        .o_tc       (gap_tc)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state             <= SER_IDLE;
            sr                <= '0;
            pending           <= 1'b0;
            o_txdat           <= 1'b0;
            o_txclk_en        <= 1'b0;
            o_ser_done        <= 1'b0;
            o_packet_finished <= 1'b0;
            o_load_ack        <= 1'b0;
            o_zero_word       <= 1'b0;
            o_overrun         <= 1'b0;
        end else begin
            state             <= state_next;
            sr                <= sr_next;
            pending           <= pending_next;
            o_txdat           <= txdat_next;
            o_txclk_en        <= txclk_en_next;
            o_ser_done        <= ser_done_next;
            o_packet_finished <= pkt_fin_next;
            o_load_ack        <= load_ack_next;
            o_zero_word       <= zero_word_next;
            o_overrun         <= overrun_next;
        end
    end

    // A word accepted during GAP waits in sr behind 'pending' until the gap expires.
    always_comb begin
        state_next     = state;
        sr_next        = sr;
        pending_next   = pending;
        txdat_next     = o_txdat;
        txclk_en_next  = 1'b0;
        ser_done_next  = 1'b0;
        pkt_fin_next   = o_packet_finished;
        load_ack_next  = 1'b0;
        zero_word_next = 1'b0;
        overrun_next   = 1'b0;
        bit_clear      = 1'b0;
        bit_load       = 1'b0;
        bit_inc        = 1'b0;
        gap_clear      = 1'b0;
        gap_inc        = 1'b0;

        case (state)
            SER_IDLE: begin
                txdat_next = 1'b0;
                if (i_load) begin
                    load_ack_next = 1'b1;
                    if (i_data == '0) begin
                        zero_word_next = 1'b1;
                    end else begin
                        sr_next    = i_data;
                        state_next = SER_LOADED;
                    end
                end
            end

            SER_LOADED: begin
                overrun_next = i_load;
                if (i_clk_en) begin
                    txdat_next    = sr[0];
                    sr_next       = sr >> 1;
                    txclk_en_next = 1'b1;
                    bit_load      = 1'b1;
                    state_next    = SER_SHIFT;
                end
            end

            SER_SHIFT: begin
                overrun_next = i_load;
                if (i_clk_en) begin
                    txdat_next    = sr[0];
                    sr_next       = sr >> 1;
                    txclk_en_next = 1'b1;
                    if (bit_tc) begin
                        ser_done_next = 1'b1;
                        pkt_fin_next  = 1'b1;
                        bit_clear     = 1'b1;
                        gap_clear     = 1'b1;
                        state_next    = SER_GAP;
                    end else begin
                        bit_inc = 1'b1;
                    end
                end
            end

            SER_GAP: begin
                txdat_next = 1'b0;
                gap_inc    = 1'b1;
                if (i_load) begin
                    if (pending) begin
                        overrun_next = 1'b1;
                    end else begin
                        load_ack_next = 1'b1;
                        if (i_data == '0) begin
                            zero_word_next = 1'b1;
                        end else begin
                            sr_next      = i_data;
                            pending_next = 1'b1;
                        end
                    end
                end
                if (gap_tc) begin
                    pkt_fin_next = 1'b0;
                    gap_clear    = 1'b1;
                    state_next   = pending_next ? SER_LOADED : SER_IDLE;
                    pending_next = 1'b0;
                end
            end

            default: begin
                state_next = SER_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_sb_tx_serializer.sv
// Scoreboard bench for sb_tx_serializer: stimulus queues expected bits/events, a negedge monitor checks them.
module tb_sb_tx_serializer;
    import sb_pkg::*;

    localparam int DATA_W = SB_DATA_W;
    localparam int GAP_UI = SB_GAP_UI;
    localparam int IDLE_MARK = 1000;

    logic              clk = 1'b0;
    logic              i_rst = 1'b1;
    logic              i_load = 1'b0;
    logic [DATA_W-1:0] i_data = '0;
    logic              i_clk_en = 1'b0;
    logic o_load_ack, o_zero_word, o_txdat, o_txclk_en, o_ser_done, o_packet_finished, o_overrun;

    sb_tx_serializer dut (
        .i_clk             (clk),
        .i_rst             (i_rst),
        .i_load            (i_load),
        .i_data            (i_data),
        .i_clk_en          (i_clk_en),
        .o_load_ack        (o_load_ack),
        .o_zero_word       (o_zero_word),
        .o_txdat           (o_txdat),
        .o_txclk_en        (o_txclk_en),
        .o_ser_done        (o_ser_done),
        .o_packet_finished (o_packet_finished),
        .o_overrun         (o_overrun)
    );

    always #5 clk = ~clk;

    int checks_total  = 0;
    int checks_passed = 0;

    // Reference model: bits expected on the lane in order, and {ack,zero,overrun} pulses in order.
    logic       bit_q[$];
    logic [2:0] ev_q[$];
    int         bit_idx    = 0;
    int         since_done = IDLE_MARK;
    logic       last_bit   = 1'b0;
    logic       mon_en     = 1'b0;
    logic       mon_done;
    logic       exp_bit;
    logic [2:0] exp_ev;

    int  pause_left = 0;
    bit  rand_en    = 1'b0;

    function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
        checks_total++;
        if (act === exp) checks_passed++;
        else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    endfunction

    function automatic void fail_now(string name);
        checks_total++;
        $display("[TB] FAIL %s at %0t", name, $time);
    endfunction

    // Monitor: every cycle, compare the lane against the spec rules and the expected-bit queue.
    always @(negedge clk) begin
        if (mon_en) begin
            mon_done = 1'b0;
            if (since_done < IDLE_MARK) since_done++;
            if (since_done >= 1 && since_done <= GAP_UI) begin
                check("gap_txclk_en", 64'(o_txclk_en), 64'd0);
                check("gap_txdat", 64'(o_txdat), 64'd0);
            end
            if (o_txclk_en) begin
                if (bit_q.size() == 0) begin
                    fail_now("unexpected_bit");
                end else begin
                    exp_bit = bit_q.pop_front();
                    check($sformatf("bit%0d", bit_idx), 64'(o_txdat), 64'(exp_bit));
                    last_bit = o_txdat;
                    if (bit_idx == DATA_W - 1) begin
                        mon_done   = 1'b1;
                        bit_idx    = 0;
                        since_done = 0;
                    end else begin
                        bit_idx++;
                    end
                end
            end else if (bit_idx > 0) begin
                check("pause_hold", 64'(o_txdat), 64'(last_bit));
            end
            check("ser_done", 64'(o_ser_done), 64'(mon_done));
            check("packet_finished", 64'(o_packet_finished), 64'(since_done < GAP_UI));
            if (o_load_ack || o_zero_word || o_overrun) begin
                if (ev_q.size() == 0) begin
                    fail_now("unexpected_event");
                end else begin
                    exp_ev = ev_q.pop_front();
                    check("event_flags", 64'({o_load_ack, o_zero_word, o_overrun}), 64'(exp_ev));
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        i_load = 1'b0;
        if (pause_left > 0) begin
            i_clk_en = 1'b0;
            pause_left--;
        end else if (rand_en) begin
            i_clk_en = ($urandom_range(0, 3) != 0);
        end else begin
            i_clk_en = 1'b1;
        end
    endtask

    task automatic apply_stimulus(input logic [DATA_W-1:0] w);
        tick();
        i_load = 1'b1;
        i_data = w;
        if (w == '0) begin
            ev_q.push_back(3'b110);
        end else begin
            ev_q.push_back(3'b100);
            for (int i = 0; i < DATA_W; i++) bit_q.push_back(w[i]);
        end
    endtask

    task automatic send_overrun(input logic [DATA_W-1:0] w);
        tick();
        i_load = 1'b1;
        i_data = w;
        ev_q.push_back(3'b001);
    endtask

    task automatic wait_bits(input int n);
        int k = 0;
        while (bit_idx < n && k < 2000) begin
            tick();
            k++;
        end
        if (k >= 2000) fail_now("wait_bits_timeout");
    endtask

    task automatic wait_gap(input int n);
        int k = 0;
        while (since_done != n && k < 2000) begin
            tick();
            k++;
        end
        if (k >= 2000) fail_now("wait_gap_timeout");
    endtask

    task automatic wait_drained();
        int k = 0;
        while (bit_q.size() != 0 && k < 4000) begin
            tick();
            k++;
        end
        if (k >= 4000) fail_now("wait_drained_timeout");
    endtask

    task automatic wait_idle();
        int k = 0;
        while (!(bit_q.size() == 0 && ev_q.size() == 0 && bit_idx == 0 &&
                 since_done > GAP_UI + 1) && k < 4000) begin
            tick();
            k++;
        end
        if (k >= 4000) fail_now("wait_idle_timeout");
        repeat (2) tick();
    endtask

    task automatic check_output();
        @(negedge clk);
        check("reset_outputs",
              64'({o_load_ack, o_zero_word, o_txdat, o_txclk_en, o_ser_done, o_packet_finished, o_overrun}),
              64'd0);
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog_timeout");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [DATA_W-1:0] w;
        i_rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_output();
        @(posedge clk);
        #1;
        i_rst  = 1'b0;
        mon_en = 1'b1;

        $display("[TB] directed word, enable held high");
        apply_stimulus(64'hA5A5_0000_FFFF_1234);
        wait_idle();

        $display("[TB] same word with a 5-cycle enable pause mid-packet");
        apply_stimulus(64'hA5A5_0000_FFFF_1234);
        wait_bits(11);
        pause_left = 5;
        wait_idle();

        $display("[TB] zero word is dropped");
        apply_stimulus('0);
        repeat (6) tick();
        wait_idle();

        $display("[TB] second load during the gap");
        apply_stimulus({$urandom, $urandom} | 64'h1);
        wait_gap(10);
        apply_stimulus({$urandom, $urandom} | 64'h8000_0000_0000_0000);
        wait_idle();

        $display("[TB] load during shift raises overrun");
        apply_stimulus({$urandom, $urandom} | 64'h2);
        wait_bits(20);
        send_overrun(64'hFFFF_FFFF_FFFF_FFFF);
        wait_idle();

        $display("[TB] load while word held raises overrun");
        pause_left = 3;
        apply_stimulus(64'h0123_4567_89AB_CDEF);
        send_overrun(64'hDEAD_BEEF_DEAD_BEEF);
        wait_idle();

        $display("[TB] reset mid-packet");
        apply_stimulus({$urandom, $urandom} | 64'h4);
        wait_bits(30);
        i_rst = 1'b1;
        tick();
        i_rst = 1'b0;
        bit_q.delete();
        ev_q.delete();
        bit_idx    = 0;
        since_done = IDLE_MARK;
        check_output();
        apply_stimulus(64'hC3C3_5A5A_0F0F_9669);
        wait_idle();

        $display("[TB] randomized words and enables");
        rand_en = 1'b1;
        for (int n = 0; n < 16; n++) begin
            w = {$urandom, $urandom};
            if ($urandom_range(0, 5) == 0) w = '0;
            apply_stimulus(w);
            wait_drained();
            repeat ($urandom_range(0, 40)) tick();
        end
        wait_idle();

        check("bit_queue_empty", 64'(bit_q.size()), 64'd0);
        check("event_queue_empty", 64'(ev_q.size()), 64'd0);

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
